// File: rtl/la_oai222_bist.sv
// Built-in self-test sequencer for one oai222 cell: sweeps all 64 input vectors,
// samples z after a settle window and records error count and first failing vector.
module la_oai222_bist #(
    parameter string PROP   = "DEFAULT",
    parameter int    SETTLE = 2,
    parameter int    CW     = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          dut_z,
    output logic          dut_a0,
    output logic          dut_a1,
    output logic          dut_b0,
    output logic          dut_b1,
    output logic          dut_c0,
    output logic          dut_c1,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [CW-1:0] err_count,
    output logic          fail_valid,
    output logic [5:0]    fail_vec
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0]    SETTLE_V = 8'(SETTLE);
    localparam logic [CW-1:0] ERR_MAX  = '1;

    state_t        state_q, state_d;
    logic [5:0]    vec_q, vec_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [CW-1:0] err_q, err_d;
    logic          fv_q, fv_d;
    logic [5:0]    fvec_q, fvec_d;
    logic          exp_z;
    logic          mismatch;

    // Golden oai222 function of the vector currently on the cell pins.
    assign exp_z    = ~((vec_q[0] | vec_q[1]) & (vec_q[2] | vec_q[3]) & (vec_q[4] | vec_q[5]));
    assign mismatch = (dut_z != exp_z);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fv_d    = fv_q;
        fvec_d  = fvec_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    vec_d   = 6'd0;
                    cnt_d   = SETTLE_V;
                    err_d   = '0;
                    fv_d    = 1'b0;
                    fvec_d  = 6'd0;
                end
            end
            S_RUN: begin
                if (cnt_q == 8'd0) begin
                    // Sample edge: the current vector has been held SETTLE+1 cycles.
                    if (mismatch) begin
                        if (err_q != ERR_MAX) begin
                            err_d = err_q + CW'(1);
                        end
                        if (!fv_q) begin
                            fv_d   = 1'b1;
                            fvec_d = vec_q;
                        end
                    end
                    if (vec_q == 6'd63) begin
                        state_d = S_DONE;
                        vec_d   = 6'd0;
                    end else begin
                        vec_d = vec_q + 6'd1;
                        cnt_d = SETTLE_V;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            vec_q   <= 6'd0;
            cnt_q   <= 8'd0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            fvec_q  <= 6'd0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            fvec_q  <= fvec_d;
        end
    end

    assign {dut_c1, dut_c0, dut_b1, dut_b0, dut_a1, dut_a0} = vec_q;
    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign pass       = done && (err_q == '0);
    assign err_count  = err_q;
    assign fail_valid = fv_q;
    assign fail_vec   = fvec_q;

endmodule

// File: tb/tb_la_oai222_bist.sv
// Bench for la_oai222_bist: a cycle-time model of the sweep checked every cycle,
// plus directed runs (ideal cell, stuck-at faults, held start, mid-run reset).
module tb_la_oai222_bist;

    localparam int SETTLE  = 2;
    localparam int CW      = 7;
    localparam int VEC_CYC = SETTLE + 1;
    localparam int RUN_CYC = 64 * VEC_CYC;
    localparam int ERR_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    int   fault_mode = 0;   // 0 ideal, 1 stuck-at-1, 2 stuck-at-0

    logic          dut_z;
    logic          a0, a1, b0, b1, c0, c1;
    logic          busy, done, pass, fail_valid;
    logic [CW-1:0] err_count;
    logic [5:0]    fail_vec;

    logic          w_a0, w_a1, w_b0, w_b1, w_c0, w_c1;
    logic          w_busy, w_done, w_pass, w_fv;
    logic [3:0]    w_err;
    logic [5:0]    w_fvec;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic golden(input logic [5:0] v);
        logic any_a, any_b, any_c;
        any_a = (v[1:0] != 2'b00);
        any_b = (v[3:2] != 2'b00);
        any_c = (v[5:4] != 2'b00);
        return !(any_a && any_b && any_c);
    endfunction

    function automatic logic cell_z(input logic [5:0] v, input int mode);
        if (mode == 1) return 1'b1;
        if (mode == 2) return 1'b0;
        return golden(v);
    endfunction

    assign dut_z = cell_z({c1, c0, b1, b0, a1, a0}, fault_mode);

    la_oai222_bist #(.PROP("DEFAULT"), .SETTLE(SETTLE), .CW(CW)) u_dut (
        .clk(clk), .reset(reset), .start(start), .dut_z(dut_z),
        .dut_a0(a0), .dut_a1(a1), .dut_b0(b0), .dut_b1(b1), .dut_c0(c0), .dut_c1(c1),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_valid(fail_valid), .fail_vec(fail_vec)
    );

    // Narrow-counter instance whose cell is permanently stuck at 0.
    la_oai222_bist #(.PROP("DEFAULT"), .SETTLE(SETTLE), .CW(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start), .dut_z(1'b0),
        .dut_a0(w_a0), .dut_a1(w_a1), .dut_b0(w_b0), .dut_b1(w_b1), .dut_c0(w_c0), .dut_c1(w_c1),
        .busy(w_busy), .done(w_done), .pass(w_pass), .err_count(w_err),
        .fail_valid(w_fv), .fail_vec(w_fvec)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: time since the accepted start determines the vector on the pins.
    bit m_run, m_done, m_fv;
    int m_t, m_err, m_fvec;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_run = 0; m_done = 0; m_fv = 0; m_t = 0; m_err = 0; m_fvec = 0;
        end else if (!m_run && start) begin
            m_run = 1; m_done = 0; m_fv = 0; m_t = 0; m_err = 0; m_fvec = 0;
        end else if (m_run) begin
            m_t++;
            if (m_t % VEC_CYC == 0) begin
                int k;
                k = m_t / VEC_CYC - 1;
                if (cell_z(6'(k), fault_mode) != golden(6'(k))) begin
                    if (m_err < ERR_MAX) m_err++;
                    if (!m_fv) begin
                        m_fv = 1;
                        m_fvec = k;
                    end
                end
                if (k == 63) begin
                    m_run = 0;
                    m_done = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        int exp_vec;
        exp_vec = m_run ? (m_t / VEC_CYC) : 0;
        chk("vec", int'({c1, c0, b1, b0, a1, a0}), exp_vec);
        chk("busy", int'(busy), int'(m_run));
        chk("done", int'(done), int'(m_done));
        chk("pass", int'(pass), int'(m_done && m_err == 0));
        chk("err_count", int'(err_count), m_err);
        chk("fail_valid", int'(fail_valid), int'(m_fv));
        chk("fail_vec", int'(fail_vec), m_fvec);
    end

    task automatic wait_done(input int init, output int busy_n);
        int guard;
        busy_n = init;
        guard = 0;
        while (!done && guard < 4 * RUN_CYC) begin
            @(negedge clk);
            if (busy) busy_n++;
            guard++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic run(input bit release_start, output int busy_n);
        start = 1'b1;
        @(negedge clk);
        if (release_start) start = 1'b0;
        wait_done(busy ? 1 : 0, busy_n);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err_count), 0);
        chk("rst_vec", int'({c1, c0, b1, b0, a1, a0}), 0);
        reset = 1'b0;
        @(negedge clk);

        fault_mode = 0;
        run(1'b1, n);
        chk("ideal_len", n, 192);
        chk("ideal_pass", int'(pass), 1);
        chk("ideal_err", int'(err_count), 0);
        chk("ideal_fv", int'(fail_valid), 0);

        fault_mode = 1;
        run(1'b1, n);
        chk("sa1_len", n, 192);
        chk("sa1_err", int'(err_count), 27);
        chk("sa1_fv", int'(fail_valid), 1);
        chk("sa1_fvec", int'(fail_vec), 21);
        chk("sa1_pass", int'(pass), 0);

        fault_mode = 2;
        run(1'b1, n);
        chk("sa0_err", int'(err_count), 37);
        chk("sa0_fvec", int'(fail_vec), 0);
        chk("sa0_fv", int'(fail_valid), 1);
        chk("cw4_err", int'(w_err), 15);
        chk("cw4_done", int'(w_done), 1);

        // start held high: one run, then a restart on the edge after done.
        fault_mode = 1;
        run(1'b0, n);
        chk("held_len1", n, 192);
        chk("held_err1", int'(err_count), 27);
        @(negedge clk);
        chk("held_restart_busy", int'(busy), 1);
        chk("held_restart_done", int'(done), 0);
        chk("held_restart_err", int'(err_count), 0);
        start = 1'b0;
        wait_done(busy ? 1 : 0, n);
        chk("held_len2", n, 192);
        chk("held_err2", int'(err_count), 27);

        // Reset mid-run, then a clean full run.
        fault_mode = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_vec", int'({c1, c0, b1, b0, a1, a0}), 0);
        chk("mid_rst_err", int'(err_count), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run(1'b1, n);
        chk("post_rst_len", n, 192);
        chk("post_rst_pass", int'(pass), 1);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/la_oai222_bist.md
Name: la_oai222_bist

Overview:
- Self-test sequencer that drives the six inputs of an oai222 cell instance and checks its `z` output.
- It is the stimulus/check end of the cell's pin interface: it generates all 64 input vectors and compares `z` against the golden function `~((a0|a1)&(b0|b1)&(c0|c1))`.
- It reports pass/fail, an error count and the first failing vector.
- Used in library characterisation benches and on-die cell-health monitors.

Parameters:
- PROP, "DEFAULT", implementation property string passed through; no functional effect.
- SETTLE, 2, cycles each vector is held before `z` is sampled. Legal range 1..255.
- CW, 7, error counter width. The counter saturates at 2^CW-1.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  run request, sampled on rising edge.
- dut_z  input  1  `z` output of the cell under test.
- dut_a0  output  1  cell input, vector bit 0.
- dut_a1  output  1  cell input, vector bit 1.
- dut_b0  output  1  cell input, vector bit 2.
- dut_b1  output  1  cell input, vector bit 3.
- dut_c0  output  1  cell input, vector bit 4.
- dut_c1  output  1  cell input, vector bit 5.
- busy  output  1  run in progress.
- done  output  1  run complete; level, held until the next accepted start.
- pass  output  1  high only when done=1 and err_count=0.
- err_count  output  CW  number of mismatching vectors, saturating.
- fail_valid  output  1  at least one mismatch captured this run.
- fail_vec  output  6  first mismatching vector {c1,c0,b1,b0,a1,a0}.

Behaviour:
- Clock and reset: one clock (`clk`). Reset (`reset`) is asynchronous and active-high.
- Reset values, all outputs:
  - busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_vec=0.
  - dut_* = 0 (vector 0).
- All outputs are registered; `pass` may be decoded from registers.
- State machine: IDLE, RUN, DONE.
- IDLE/DONE, start=1 at edge E0:
  - go to RUN; busy=1, done=0.
  - clear err_count, fail_valid and fail_vec.
  - vector index v=0, settle counter=SETTLE.
- RUN, per vector:
  - Vector k is driven on dut_* during cycles E0+k*(SETTLE+1) up to E0+(k+1)*(SETTLE+1).
  - dut_z is sampled at edge E0+(k+1)*(SETTLE+1), where it is compared with the expected value exp(v).
  - Each vector therefore occupies exactly SETTLE+1 cycles.
  - dut_z is treated as combinational from the dut_* registers; it is not resynchronised.
- On mismatch:
  - err_count increments, holding at 2^CW-1.
  - If fail_valid=0, set fail_valid=1 and fail_vec=v. Later mismatches do not overwrite it.
- On the sample edge of v=63: go to DONE; busy=0, done=1, and dut_* return to 0 on the same edge.
- Total run length: 64*(SETTLE+1) cycles from E0 to the done rising edge.
- start while in RUN is ignored; the run is not restarted or extended.
- start in DONE begins a new run exactly as from IDLE. Results clear at E0.
- In IDLE/DONE, dut_* hold 0. Results hold until the next accepted start.
- Reset asserted mid-run: immediate return to IDLE with reset values; the partial run is discarded.
- After reset deasserts, the first start accepted is on the first rising edge with start=1.
- Expected value: exp(v) = ~((v[0]|v[1]) & (v[2]|v[3]) & (v[4]|v[5])). Exactly 27 vectors expect 0 and 37 expect 1.

Test Plan:
- Ideal cell model, SETTLE=2, one-cycle start pulse:
  - busy for 192 cycles, then done=1, pass=1, err_count=0, fail_valid=0.
  - dut_* sweeps 0..63, each vector held 3 cycles.
- dut_z stuck-at-1 → err_count=27, fail_valid=1, fail_vec=6'b010101 (21), pass=0.
- dut_z stuck-at-0 with CW=7 → err_count=37, fail_vec=0.
- Same stuck-at-0 fault with CW=4 → err_count saturates at 15.
- start held high continuously through a run → exactly one run of 192 cycles. A second run begins on the first edge after done rises, clearing err_count.
- reset pulsed at cycle 50 of a run → all outputs at reset values within the reset cycle; a subsequent start yields a full, correct 192-cycle run.
